fixed_vec_streamer: RTL and testbench

// Initiator/source side of the fixed-point MAC stream interface. Holds two signed

---
 rtl/fixed_stream_pkg.sv | 30 +++
 rtl/stream_src_ch.sv | 90 +++++++++
 rtl/fixed_vec_streamer.sv | 194 +++++++++++++++++++
 tb/tb_fixed_vec_streamer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_stream_pkg.sv
// Shared types and default widths for the fixed-point vector streamer.
// The optional result watchdog is enabled with FIXED_STREAM_TIMEOUT_EN.
package fixed_stream_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RES = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam int DEF_WI1         = 4;
  localparam int DEF_WF1         = 8;
  localparam int DEF_WI2         = 3;
  localparam int DEF_WF2         = 5;
  localparam int DEF_WIO         = 15;
  localparam int DEF_WFO         = 30;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_TIMEOUT_CYC = 1024;

  // Total bit width of a signed fixed-point format WI.WF
  function automatic int fx_width(input int wi, input int wf);
    return wi + wf;
  endfunction

  localparam int A_W = fx_width(DEF_WI1, DEF_WF1);
  localparam int B_W = fx_width(DEF_WI2, DEF_WF2);
  localparam int O_W = fx_width(DEF_WIO, DEF_WFO);

endpackage

// File: rtl/stream_src_ch.sv
// One source channel: host-loaded buffer plus index counter driving a
// registered valid/data/last stream of len beats after each launch.
module stream_src_ch #(
  parameter int W     = 12,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          launch,
  input  logic [AW:0]   len,
  input  logic          ready,
  output logic [W-1:0]  data,
  output logic          valid,
  output logic          last,
  output logic          fin
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  idx_q, idx_d;
  logic [AW:0]  len_q, len_d;
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic         fin_q, fin_d;

  // Host write port into the element buffer
  // NOTE: the buffer has no reset; only control state needs a known value.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Next-state: load element 0 on launch, then the next element on each beat
  // NOTE: every signal gets its hold value first so no latch is inferred.
  always_comb begin
    idx_d   = idx_q;
    len_d   = len_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    fin_d   = fin_q;
    if (launch) begin
      idx_d   = (AW+1)'(1);
      len_d   = len;
      data_d  = mem_q[0];
      valid_d = 1'b1;
      last_d  = (len == (AW+1)'(1));
      fin_d   = 1'b0;
    end else if (valid_q && ready) begin
      if (last_q) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        fin_d   = 1'b1;
      end else begin
        data_d = mem_q[idx_q[AW-1:0]];
        last_d = (idx_q == len_q - (AW+1)'(1));
        idx_d  = idx_q + (AW+1)'(1);
      end
    end
  end

  // Stream registers; reset drops valid immediately
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      len_q   <= len_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      fin_q   <= fin_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign last  = last_q;
  assign fin   = fin_q;

endmodule

// File: rtl/fixed_vec_streamer.sv
// Source side of the fixed-point MAC stream: streams buffered A/B vectors,
// then captures the MAC result and saturation flags.
// Define FIXED_STREAM_TIMEOUT_EN to add a result-wait watchdog of TIMEOUT_CYC cycles.
module fixed_vec_streamer
  import fixed_stream_pkg::*;
#(
  parameter int WI1         = DEF_WI1,
  parameter int WF1         = DEF_WF1,
  parameter int WI2         = DEF_WI2,
  parameter int WF2         = DEF_WF2,
  parameter int WIO         = DEF_WIO,
  parameter int WFO         = DEF_WFO,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int AW   = $clog2(DEPTH),
  localparam int A_DW = fx_width(WI1, WF1),
  localparam int B_DW = fx_width(WI2, WF2),
  localparam int O_DW = fx_width(WIO, WFO)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [A_DW-1:0] wr_a_data,
  input  logic [B_DW-1:0] wr_b_data,
  input  logic [AW:0]     len,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [O_DW-1:0] result,
  output logic            res_of,
  output logic            res_uf,
  output logic [A_DW-1:0] A_data,
  output logic            A_valid,
  input  logic            A_ready,
  output logic            A_last,
  output logic [B_DW-1:0] B_data,
  output logic            B_valid,
  input  logic            B_ready,
  output logic            B_last,
  input  logic [O_DW-1:0] out_data,
  input  logic            out_valid,
  output logic            out_ready,
  input  logic            out_last,
  input  logic            overflow,
  input  logic            underflow
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [O_DW-1:0] result_q, result_d;
  logic            res_of_q, res_of_d;
  logic            res_uf_q, res_uf_d;
  logic            out_ready_q, out_ready_d;
  logic            launch;
  logic            wr_ok;
  logic            a_fin, b_fin;
  logic            len_ok;

  // The MAC's last marker carries no control meaning here
  logic unused_out_last;
  assign unused_out_last = out_last;

`ifdef FIXED_STREAM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign len_ok = (len != '0) && (len <= LEN_MAX);
  assign wr_ok  = wr_en && !busy_q;

  stream_src_ch #(.W(A_DW), .DEPTH(DEPTH)) u_ch_a (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_a_data),
    .launch  (launch),
    .len     (len),
    .ready   (A_ready),
    .data    (A_data),
    .valid   (A_valid),
    .last    (A_last),
    .fin     (a_fin)
  );

  stream_src_ch #(.W(B_DW), .DEPTH(DEPTH)) u_ch_b (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_b_data),
    .launch  (launch),
    .len     (len),
    .ready   (B_ready),
    .data    (B_data),
    .valid   (B_valid),
    .last    (B_last),
    .fin     (b_fin)
  );

  // Control FSM next-state and registered-output values
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    res_of_d = res_of_q;
    res_uf_d = res_uf_q;
    err_d    = 1'b0;
    launch   = 1'b0;
`ifdef FIXED_STREAM_TIMEOUT_EN
    tmo_d    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d = SEND;
            launch  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (a_fin && b_fin) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (out_valid && out_ready_q) begin
          state_d  = DONE;
          result_d = out_data;
          res_of_d = overflow;
          res_uf_d = underflow;
        end
`ifdef FIXED_STREAM_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d  = DONE;
          result_d = '0;
          res_of_d = 1'b1;
          res_uf_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    out_ready_d = (state_d == WAIT_RES);
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
      res_of_q    <= 1'b0;
      res_uf_q    <= 1'b0;
      out_ready_q <= 1'b0;
`ifdef FIXED_STREAM_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      result_q    <= result_d;
      res_of_q    <= res_of_d;
      res_uf_q    <= res_uf_d;
      out_ready_q <= out_ready_d;
`ifdef FIXED_STREAM_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign res_of    = res_of_q;
  assign res_uf    = res_uf_q;
  assign out_ready = out_ready_q;

endmodule

// File: tb/tb_fixed_vec_streamer.sv
// Scoreboard bench for fixed_vec_streamer: stimulus pushes expected beats and
// results into queues, monitors pop and compare on each handshake / done pulse.
// The watchdog scenario runs only when FIXED_STREAM_TIMEOUT_EN is defined.
module tb_fixed_vec_streamer;

`ifdef FIXED_STREAM_TIMEOUT_EN
  localparam int TMO      = 8;
  localparam int RESP_DLY = 3;
`else
  localparam int TMO      = 1024;
  localparam int RESP_DLY = 20;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [11:0] wr_a_data = '0;
  logic [7:0]  wr_b_data = '0;
  logic [4:0]  len = '0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [44:0] result;
  logic        res_of, res_uf;
  logic [11:0] A_data;
  logic        A_valid, A_last;
  logic        A_ready = 1'b1;
  logic [7:0]  B_data;
  logic        B_valid, B_last;
  logic        B_ready = 1'b1;
  logic [44:0] out_data = '0;
  logic        out_valid = 1'b0;
  logic        out_ready;
  logic        out_last = 1'b0;
  logic        overflow = 1'b0;
  logic        underflow = 1'b0;

  fixed_vec_streamer #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_a_data(wr_a_data), .wr_b_data(wr_b_data), .len(len), .start(start),
    .busy(busy), .done(done), .err(err), .result(result),
    .res_of(res_of), .res_uf(res_uf),
    .A_data(A_data), .A_valid(A_valid), .A_ready(A_ready), .A_last(A_last),
    .B_data(B_data), .B_valid(B_valid), .B_ready(B_ready), .B_last(B_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int a_beats = 0, b_beats = 0, done_cnt = 0;
  int a_last_cyc = 0, b_last_cyc = 0;

  logic [11:0] a_mem [16];
  logic [7:0]  b_mem [16];
  logic [12:0] exp_a [$];
  logic [8:0]  exp_b [$];
  logic [46:0] exp_r [$];

  logic        stall_on = 1'b0;
  logic        a_stall = 1'b0, b_stall = 1'b0;
  logic [12:0] a_hold = '0;
  logic [8:0]  b_hold = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    chk_cnt++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc++;

  // A-channel monitor: beat contents and hold-while-stalled
  always @(negedge clk) begin
    if (!reset_n) a_stall = 1'b0;
    else begin
      if (a_stall && A_valid) check("a_hold", {A_last, A_data}, a_hold);
      if (A_valid && A_ready) begin
        if (exp_a.size() == 0) fail_now("a_extra_beat");
        else check("a_beat", {A_last, A_data}, exp_a.pop_front());
        a_beats++;
        if (A_last) a_last_cyc = cyc;
      end
      a_stall = A_valid && !A_ready;
      a_hold  = {A_last, A_data};
    end
  end

  // B-channel monitor
  always @(negedge clk) begin
    if (!reset_n) b_stall = 1'b0;
    else begin
      if (b_stall && B_valid) check("b_hold", {B_last, B_data}, b_hold);
      if (B_valid && B_ready) begin
        if (exp_b.size() == 0) fail_now("b_extra_beat");
        else check("b_beat", {B_last, B_data}, exp_b.pop_front());
        b_beats++;
        if (B_last) b_last_cyc = cyc;
      end
      b_stall = B_valid && !B_ready;
      b_hold  = {B_last, B_data};
    end
  end

  // Result monitor: compares captured result and flags on each done pulse
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (exp_r.size() == 0) fail_now("unexpected_done");
      else check("result", {res_uf, res_of, result}, exp_r.pop_front());
      done_cnt++;
    end
  end

  // A_ready stall pattern, LSB first
  initial begin
    logic [15:0] pat;
    pat = 16'b1001_0010_0100_0000;
    forever begin
      @(posedge clk);
      if (stall_on) begin
        #1 A_ready = pat[cyc % 16];
      end
    end
  end

  task automatic wr(input int addr, input logic [11:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 4'(addr); wr_a_data = a; wr_b_data = b;
    a_mem[addr] = a; b_mem[addr] = b;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) begin
      exp_a.push_back({(i == n - 1) ? 1'b1 : 1'b0, a_mem[i]});
      exp_b.push_back({(i == n - 1) ? 1'b1 : 1'b0, b_mem[i]});
    end
  endtask

  // Pulse start for one cycle and check valids rise right after the accept edge
  task automatic do_start(input int n);
    @(posedge clk); #1;
    check("pre_start_valid", {A_valid, B_valid}, 2'b00);
    len = 5'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_valid", {A_valid, B_valid, busy}, 3'b111);
  endtask

  task automatic wait_out_ready(input int bound);
    int k;
    k = 0;
    while (!out_ready && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    if (!out_ready) fail_now("out_ready_timeout");
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (!done && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    if (!done) fail_now("done_timeout");
    @(posedge clk); #1;
    check("done_pulse_end", {done, busy}, 2'b00);
  endtask

  task automatic respond(input int dly, input logic [44:0] d, input logic of, input logic uf);
    exp_r.push_back({uf, of, d});
    repeat (dly) @(posedge clk);
    #1;
    out_valid = 1'b1; out_data = d; overflow = of; underflow = uf;
    @(posedge clk); #1;
    out_valid = 1'b0; overflow = 1'b0; underflow = 1'b0;
  endtask

  task automatic reject(input int n);
    @(posedge clk); #1;
    len = 5'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("reject_err", {err, A_valid, B_valid, busy}, 4'b1000);
    @(posedge clk); #1;
    check("reject_after", {err, A_valid, B_valid, busy}, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int a0, b0;
    logic err_seen;

    // Reset state
    #23;
    check("rst_ctrl", {busy, done, err, out_ready, A_valid, B_valid, A_last, B_last}, 8'h00);
    check("rst_result", {res_uf, res_of, result}, 47'h0);
    check("rst_data", {A_data, B_data}, 20'h0);
    reset_n = 1'b1;

    // 1.0*1.0 + 2.0*1.0 + (-0.5)*2.0 = 2.0, streamed with ready held high
    wr(0, 12'h100, 8'h20);
    wr(1, 12'h200, 8'h20);
    wr(2, 12'hF80, 8'h40);
    push_exp(3);
    do_start(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b2b_valid", {A_valid, B_valid}, 2'b11);
    end
    @(negedge clk);
    check("after_last_valid", {A_valid, B_valid}, 2'b00);
    wait_out_ready(20);
    respond(0, 45'h0_8000_0000, 1'b0, 1'b0);
    wait_done(20);

    // A stalled by a ready pattern, B free-running
    a0 = a_beats;
    A_ready = 1'b0;
    stall_on = 1'b1;
    push_exp(3);
    do_start(3);
    wait_out_ready(100);
    check("stall_a_beats_before_wait", 64'(a_beats - a0), 64'd3);
    check("b_finished_first", 64'(b_last_cyc < a_last_cyc), 64'd1);
    stall_on = 1'b0;
    A_ready = 1'b1;
    respond(0, 45'h123_4567_89AB, 1'b0, 1'b1);
    wait_done(20);

    // Single-element vector: first beat is also last
    push_exp(1);
    do_start(1);
    check("len1_last", {A_last, B_last}, 2'b11);
    wait_out_ready(20);
    respond(0, 45'h0_4000_0000, 1'b0, 0);
    wait_done(20);

    // Illegal lengths
    reject(0);
    reject(17);

    // Late result with overflow
    push_exp(2);
    do_start(2);
    wait_out_ready(20);
    respond(RESP_DLY, 45'h1FFF_FFFF_FFFF, 1'b1, 1'b0);
    wait_done(40);

    // start held high while busy, plus a buffer write that must be dropped
    a0 = a_beats; b0 = b_beats;
    err_seen = 1'b0;
    push_exp(2);
    @(posedge clk); #1;
    len = 5'd2; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (err) err_seen = 1'b1;
      wr_en = (i == 3); wr_addr = 4'd0; wr_a_data = 12'hABC; wr_b_data = 8'h55;
    end
    start = 1'b0; wr_en = 1'b0;
    check("held_start_no_err", 64'(err_seen), 64'd0);
    wait_out_ready(20);
    respond(0, 45'h0_0000_1234, 1'b0, 1'b0);
    wait_done(20);
    check("held_start_one_txn", 64'((a_beats - a0) + (b_beats - b0)), 64'd4);

    // Buffer must still hold the pre-busy element 0
    push_exp(1);
    do_start(1);
    wait_out_ready(20);
    respond(0, 45'h0_0000_0001, 1'b0, 1'b0);
    wait_done(20);

    // Reset asserted mid-SEND with both channels stalled
    A_ready = 1'b0; B_ready = 1'b0;
    do_start(3);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("reset_mid_send", {A_valid, B_valid, busy, out_ready}, 4'b0000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    A_ready = 1'b1; B_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stays_idle", {A_valid, B_valid, busy, done}, 4'b0000);

`ifdef FIXED_STREAM_TIMEOUT_EN
    // No result ever arrives: watchdog fires after TMO cycles in WAIT_RES
    begin
      int k;
      push_exp(1);
      do_start(1);
      wait_out_ready(20);
      exp_r.push_back({1'b1, 1'b1, 45'h0});
      k = 0;
      while (!done && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      check("timeout_cycles", 64'(k), 64'(TMO));
      @(posedge clk); #1;
      check("timeout_idle", {done, busy}, 2'b00);
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queues_drained", 64'(exp_a.size() + exp_b.size() + exp_r.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
